pc_branch_ctrl: RTL and testbench

- Program-counter and branch-resolution stage for the RISC CPU.
- Sits directly downstream of the branch-equal select logic and upstream of instruction fetch.
- Takes the branch operands and the BEQ/BNE select from execute, resolves whether the branch is taken, and owns the PC register.
- Also owns the flush window that squashes wrong-path instructions, plus fetch-enable, stall and halt control.

---
 rtl/pc_branch_ctrl.sv | 79 +++++++
 tb/tb_pc_branch_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pc_branch_ctrl.sv
// PC register and branch resolution for the RISC CPU front end.
// Owns the flush window after taken branches plus fetch, stall and halt control.
module pc_branch_ctrl #(
    parameter int              AW           = 8,
    parameter int              DW           = 8,
    parameter logic [AW-1:0]   RESET_PC     = '0,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Stall,
    input  logic          BrValid,
    input  logic          BrNe,
    input  logic [DW-1:0] OpA,
    input  logic [DW-1:0] OpB,
    input  logic [AW-1:0] BrTarget,
    input  logic          Halt,
    output logic [AW-1:0] PC,
    output logic          FetchEn,
    output logic          Flush,
    output logic          BrTaken,
    output logic          Halted
);

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    logic [1:0] state;
    logic [3:0] flushCnt;
    logic       taken;

    assign taken   = BrValid & ((OpA == OpB) ^ BrNe);
    assign FetchEn = (state == RUN) & ~Stall;
    assign Flush   = (state == FLUSH);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= BOOT;
            PC       <= RESET_PC;
            BrTaken  <= 1'b0;
            Halted   <= 1'b0;
            flushCnt <= '0;
        end else begin
            unique case (state)
                BOOT: begin
                    BrTaken <= 1'b0;
                    state   <= RUN;
                end
                RUN: begin
                    BrTaken <= taken;
                    // A taken branch beats both Halt and Stall.
                    if (taken) begin
                        PC       <= BrTarget;
                        flushCnt <= 4'(FLUSH_CYCLES);
                        state    <= FLUSH;
                    end else if (Halt) begin
                        Halted <= 1'b1;
                        state  <= HALT;
                    end else if (!Stall) begin
                        PC <= PC + AW'(1);
                    end
                end
                FLUSH: begin
                    BrTaken  <= 1'b0;
                    flushCnt <= flushCnt - 4'd1;
                    if (flushCnt == 4'd1) begin
                        state <= RUN;
                    end
                end
                HALT: begin
                    BrTaken <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Randomised bench for pc_branch_ctrl against a cycle-level reference model.
// Directed walk through reset, branches, stall, halt and wrap, then random traffic.
module tb_pc_branch_ctrl;

    localparam logic [7:0] RPC = 8'h10;
    localparam int         FC  = 2;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Stall = 1'b0;
    logic       BrValid = 1'b0;
    logic       BrNe = 1'b0;
    logic [7:0] OpA = '0;
    logic [7:0] OpB = '0;
    logic [7:0] BrTarget = '0;
    logic       Halt = 1'b0;
    logic [7:0] PC;
    logic       FetchEn;
    logic       Flush;
    logic       BrTaken;
    logic       Halted;

    int checks = 0;
    int errors = 0;

    bit [7:0] mPc;
    bit       mBrTaken;
    bit       mHalted;
    bit       mBoot;
    int       mFlushLeft;

    pc_branch_ctrl #(
        .AW(8), .DW(8), .RESET_PC(RPC), .FLUSH_CYCLES(FC)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .BrValid(BrValid),
        .BrNe(BrNe), .OpA(OpA), .OpB(OpB), .BrTarget(BrTarget),
        .Halt(Halt), .PC(PC), .FetchEn(FetchEn), .Flush(Flush),
        .BrTaken(BrTaken), .Halted(Halted)
    );

    always #5 Clk = ~Clk;

    task automatic checkVal(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkAll();
        bit running;
        running = !mBoot && !mHalted && (mFlushLeft == 0);
        checkVal("pc", PC, mPc);
        checkVal("fetchEn", FetchEn, running && !Stall);
        checkVal("flush", Flush, mFlushLeft > 0);
        checkVal("brTaken", BrTaken, mBrTaken);
        checkVal("halted", Halted, mHalted);
    endtask

    task automatic modelStep();
        bit eq;
        if (mBoot) begin
            mBoot    = 0;
            mBrTaken = 0;
        end else if (mHalted) begin
            mBrTaken = 0;
        end else if (mFlushLeft > 0) begin
            mFlushLeft--;
            mBrTaken = 0;
        end else begin
            eq = (OpA == OpB);
            if (BrValid && (BrNe ? !eq : eq)) begin
                mPc        = BrTarget;
                mBrTaken   = 1;
                mFlushLeft = FC;
            end else begin
                mBrTaken = 0;
                if (Halt) mHalted = 1;
                else if (!Stall) mPc = mPc + 8'd1;
            end
        end
    endtask

    task automatic cyc(input logic st, input logic bv, input logic bn,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] t, input logic h);
        Stall = st; BrValid = bv; BrNe = bn;
        OpA = a; OpB = b; BrTarget = t; Halt = h;
        @(negedge Clk);
        checkAll();
        @(posedge Clk);
        modelStep();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'h00, 8'h00, 8'h00, 0);
    endtask

    task automatic doReset();
        Rst = 1'b1;
        #1;
        mPc = RPC; mBrTaken = 0; mHalted = 0; mBoot = 1; mFlushLeft = 0;
        checkVal("rstPc", PC, RPC);
        checkVal("rstFetch", FetchEn, 0);
        checkVal("rstFlush", Flush, 0);
        checkVal("rstHalted", Halted, 0);
        checkVal("rstBrTaken", BrTaken, 0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
    endtask

    initial begin
        #2;
        doReset();
        // boot cycle then 0x10, 0x11, 0x12
        idle(4);
        checkVal("bootSeq", PC, 8'h13);
        // branch to 0x20, then BEQ taken to 0x80
        cyc(0, 1, 0, 8'h33, 8'h33, 8'h20, 0);
        idle(2);
        checkVal("preBeq", PC, 8'h20);
        cyc(0, 1, 0, 8'h5A, 8'h5A, 8'h80, 0);
        checkVal("beqPc", PC, 8'h80);
        idle(3);
        checkVal("afterFlush", PC, 8'h81);
        // not-taken BEQ and BNE
        cyc(0, 1, 0, 8'h5A, 8'h5B, 8'h44, 0);
        cyc(0, 1, 1, 8'h5A, 8'h5A, 8'h44, 0);
        checkVal("notTaken", PC, 8'h83);
        // stall, then taken BNE under stall
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 8'h00, 8'h00, 8'h00, 0);
        checkVal("stallPc", PC, 8'h83);
        cyc(1, 1, 1, 8'h01, 8'h02, 8'h40, 0);
        checkVal("stallBrPc", PC, 8'h40);
        idle(2);
        // halt with taken branch: branch wins
        cyc(0, 1, 0, 8'h07, 8'h07, 8'hFF, 1);
        checkVal("haltDropped", Halted, 0);
        idle(2);
        // wrap 0xFF -> 0x00
        cyc(0, 0, 0, 8'h00, 8'h00, 8'h00, 0);
        checkVal("wrap", PC, 8'h00);
        // halt, then ignore everything
        cyc(0, 0, 0, 8'h00, 8'h00, 8'h00, 1);
        cyc(0, 1, 0, 8'h09, 8'h09, 8'h66, 0);
        cyc(1, 1, 1, 8'h01, 8'h02, 8'h77, 1);
        checkVal("haltFrozen", PC, 8'h00);
        checkVal("haltFlag", Halted, 1);
        // reset during the 2nd flush cycle
        doReset();
        idle(2);
        cyc(0, 1, 1, 8'h01, 8'h02, 8'hA0, 0);
        idle(1);
        checkVal("midFlushIn", Flush, 1);
        doReset();
        idle(2);
        // random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] a;
            logic [7:0] b;
            if ($urandom_range(0, 99) == 0) begin
                doReset();
            end else begin
                a = 8'($urandom);
                b = $urandom_range(0, 1) ? a : 8'($urandom);
                cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                    1'($urandom), a, b, 8'($urandom),
                    $urandom_range(0, 39) == 0);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
